mem_access_ctrl: RTL and testbench

- Initiator side of the data-memory interface. It sits in the MEM stage between the pipeline (mem_r_en/mem_w_en, ALU result as address, val_rm as store data) and a word-addressed data memory that uses a req/ack handshake.
- Translates byte addresses to word indices, checks range and alignment, drives the memory request, freezes the pipeline until completion, and returns load data.
- Bounds each access with a timeout so a missing ack cannot hang the core.

---
 rtl/mem_if_pkg.sv | 24 ++
 rtl/mem_timeout_cnt.sv | 30 +++
 rtl/mem_access_ctrl.sv | 127 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the MEM-stage data-memory interface: FSM states,
// address-map defaults and the legality check used by controller and memory model.
package mem_if_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
   localparam int          WORD_SHIFT    = 2;

   // Legal = inside the window, word aligned, and within the memory depth.
   // The subtraction may wrap for addr < base, but that term is masked by the first test.
   function automatic logic addr_legal(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] depth);
      logic [31:0] idx;
      idx = (addr - base) >> WORD_SHIFT;
      return (addr >= base) && (addr[1:0] == 2'b00) && (idx < depth);
   endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter for an outstanding memory request; flags the last
// permitted cycle so the controller can abandon a request that never gets an ack.
module mem_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int             CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for a word-addressed req/ack data memory: checks the
// access, runs the handshake with a timeout, stalls the pipeline and returns load data.
module mem_access_ctrl
   import mem_if_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = BASE_ADDR_DEF,
   parameter int          DEPTH_WORDS    = 64,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] address,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        freeze,
   output logic        acc_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output state_t      fsm_state
);

   state_t      state;
   state_t      next_state;
   logic        req_v;
   logic        legal;
   logic [31:0] word_idx;
   logic        err_pending;
   logic        take_req;
   logic        err_set;
   logic        cap_rd;
   logic        clr_rd;
   logic        cnt_clr;
   logic        cnt_en;
   logic        expired;

   assign req_v    = mem_r_en | mem_w_en;
   assign legal    = addr_legal(address, BASE_ADDR, 32'(DEPTH_WORDS));
   assign word_idx = (address - BASE_ADDR) >> WORD_SHIFT;

   mem_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .expired(expired)
   );

   // An ack on the expiry cycle wins over the timeout.
   always_comb begin
      next_state = state;
      take_req   = 1'b0;
      err_set    = 1'b0;
      cap_rd     = 1'b0;
      clr_rd     = 1'b0;
      cnt_clr    = 1'b1;
      cnt_en     = 1'b0;
      case (state)
         IDLE: begin
            if (req_v) begin
               if (legal) begin
                  take_req   = 1'b1;
                  next_state = REQ;
               end else begin
                  err_set    = 1'b1;
                  next_state = DONE;
               end
            end
         end
         REQ: begin
            cnt_clr = 1'b0;
            if (mem_ack) begin
               cap_rd     = ~mem_we;
               cnt_clr    = 1'b1;
               next_state = DONE;
            end else if (expired) begin
               err_set    = 1'b1;
               clr_rd     = ~mem_we;
               cnt_clr    = 1'b1;
               next_state = DONE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         err_pending <= 1'b0;
         rd_data     <= '0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_we      <= 1'b0;
      end else begin
         state       <= next_state;
         err_pending <= err_set;
         if (take_req) begin
            mem_addr  <= word_idx;
            mem_wdata <= wr_data;
            mem_we    <= mem_w_en;
         end
         if (cap_rd) begin
            rd_data <= mem_rdata;
         end else if (clr_rd) begin
            rd_data <= '0;
         end
      end
   end

   // DONE releases the stall so the pipeline can retire the access.
   assign freeze    = req_v & (state != DONE);
   assign mem_req   = (state == REQ);
   assign acc_err   = (state == DONE) & err_pending;
   assign fsm_state = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a pipeline-side driver task issues one
// access at a time, answers the handshake, and checks latency, errors and load data.
module tb_mem_access_ctrl;
   import mem_if_pkg::*;

   logic        clk;
   logic        rst;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] address;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        freeze;
   logic        acc_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   state_t      fsm_state;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   mem_access_ctrl #(
      .BASE_ADDR     (32'd1024),
      .DEPTH_WORDS   (64),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_r_en (mem_r_en),
      .mem_w_en (mem_w_en),
      .address  (address),
      .wr_data  (wr_data),
      .rd_data  (rd_data),
      .freeze   (freeze),
      .acc_err  (acc_err),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata),
      .fsm_state(fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Entered and left at posedge+1 with the DUT in IDLE. Inputs change at
   // posedge+1, outputs are sampled and mem_ack is answered at posedge+2.
   // ack_wait = REQ cycles before the ack (-1 = never ack).
   task automatic run_access(input string tag, input logic r, input logic w,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int ack_wait, input logic [31:0] rdata,
                             input int exp_freeze, input int exp_req, input logic exp_err,
                             input logic [31:0] exp_rd, input logic [31:0] exp_maddr,
                             input logic exp_we);
      int n_freeze;
      int n_req;
      bit done;
      n_freeze = 0;
      n_req    = 0;
      done     = 0;
      mem_r_en = r;
      mem_w_en = w;
      address  = addr;
      wr_data  = wdata;
      exp_q.push_back(exp_rd);
      #1;
      check({tag, "_start_idle"}, 32'(fsm_state), 32'(IDLE));
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         mem_ack   = mem_req && (n_req == ack_wait);
         mem_rdata = rdata;
         if (mem_req) begin
            check({tag, "_mem_addr"}, mem_addr, exp_maddr);
            check({tag, "_mem_we"}, 32'(mem_we), 32'(exp_we));
            if (exp_we) check({tag, "_mem_wdata"}, mem_wdata, wdata);
            n_req++;
         end
         if (freeze) begin
            n_freeze++;
            @(posedge clk);
            #2;
         end else begin
            done = 1;
            check({tag, "_done_state"}, 32'(fsm_state), 32'(DONE));
            check({tag, "_acc_err"}, 32'(acc_err), 32'(exp_err));
            check({tag, "_rd_data"}, rd_data, exp_q.pop_front());
            check({tag, "_freeze_cycles"}, 32'(n_freeze), 32'(exp_freeze));
            check({tag, "_req_cycles"}, 32'(n_req), 32'(exp_req));
         end
      end
      if (!done) check({tag, "_bound"}, 32'(0), 32'(1));
      @(posedge clk);
      #1;
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      mem_ack  = 1'b0;
   endtask

   initial begin
      rst       = 1'b0;
      mem_r_en  = 1'b0;
      mem_w_en  = 1'b0;
      address   = '0;
      wr_data   = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_state", 32'(fsm_state), 32'(IDLE));
      check("rst_rd_data", rd_data, 32'h0);
      check("rst_mem_req", 32'(mem_req), 32'h0);
      check("rst_freeze", 32'(freeze), 32'h0);
      check("rst_acc_err", 32'(acc_err), 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);

      // stray ack while idle must be ignored
      mem_ack = 1'b1;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      #1;
      check("idle_ack_state", 32'(fsm_state), 32'(IDLE));
      check("idle_ack_req", 32'(mem_req), 32'h0);
      @(posedge clk);
      #1;

      //          tag          r  w  addr   wdata          ack rdata          frz req err rd_data        maddr we
      run_access("rd_imm",    1, 0, 1032, 32'h0,          0, 32'hDEADBEEF,   2,  1, 0, 32'hDEADBEEF, 2,  0);
      run_access("wr_wait3",  0, 1, 1024, 32'h12345678,   3, 32'h55555555,   5,  4, 0, 32'hDEADBEEF, 0,  1);
      run_access("ill_low",   1, 0, 1000, 32'h0,          0, 32'h0,          1,  0, 1, 32'hDEADBEEF, 0,  0);
      run_access("ill_align", 1, 0, 1026, 32'h0,          0, 32'h0,          1,  0, 1, 32'hDEADBEEF, 0,  0);
      run_access("ill_depth", 1, 0, 1280, 32'h0,          0, 32'h0,          1,  0, 1, 32'hDEADBEEF, 0,  0);
      run_access("rd_last",   1, 0, 1276, 32'h0,          0, 32'h0BADF00D,   2,  1, 0, 32'h0BADF00D, 63, 0);
      run_access("rd_tmo",    1, 0, 1028, 32'h0,         -1, 32'hFFFFFFFF,  17, 16, 1, 32'h0,        1,  0);

      // reset on the second REQ cycle abandons the read
      mem_r_en = 1'b1;
      address  = 1032;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("mid_rst_in_req", 32'(mem_req), 32'h1);
      rst      = 1'b0;
      mem_r_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_state", 32'(fsm_state), 32'(IDLE));
      check("mid_rst_mem_req", 32'(mem_req), 32'h0);
      check("mid_rst_freeze", 32'(freeze), 32'h0);
      check("mid_rst_rd_data", rd_data, 32'h0);
      @(posedge clk);
      #1;

      run_access("rd_after",  1, 0, 1036, 32'h0,          1, 32'hCAFEF00D,   3,  2, 0, 32'hCAFEF00D, 3,  0);
      run_access("both_en",   1, 1, 1040, 32'hA5A5A5A5,   0, 32'h77777777,   2,  1, 0, 32'hCAFEF00D, 4,  1);
      run_access("b2b_rd",    1, 0, 1044, 32'h0,          0, 32'h11223344,   2,  1, 0, 32'h11223344, 5,  0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
